// File: rtl/pixel_writer.sv
// ============================================================================
// pixel_writer : clips rasteriser pixels, buffers them and writes them to the
//                framebuffer over a req/ack port, pulsing done per line.
// Rev 1.0
// ============================================================================
`default_nettype none

module pixel_writer #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int COORD_W    = 32,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               pll_clock,
  input  logic               sys_reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               pix_last,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic [15:0]        clip_count,
  output logic               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + COLOR_W + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [PTR_W:0]       r_count;
  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic                 r_req;
  logic [ADDR_W-1:0]    r_addr;
  logic [COLOR_W-1:0]   r_data;
  logic                 r_last;
  logic                 r_done;
  logic                 r_done_pending;
  logic [15:0]          r_clip_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_oob;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_clip;
  logic                 w_pop;
  logic                 w_pend_fire;
  logic [ADDR_W-1:0]    w_addr;
  logic [ADDR_W-1:0]    w_head_addr;
  logic [COLOR_W-1:0]   w_head_data;
  logic                 w_head_last;

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // Ready depends only on occupancy, never on mem_ack.
  assign pix_ready = sys_reset & ~w_full;

  assign w_oob    = (pix_x >= COORD_W'(SCREEN_W)) || (pix_y >= COORD_W'(SCREEN_H));
  assign w_accept = pix_valid & pix_ready;
  assign w_push   = w_accept & ~w_oob;
  assign w_clip   = w_accept & w_oob;
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;

  // Low address bits depend only on low operand bits, so the product is formed at ADDR_W.
  assign w_addr = pix_y[ADDR_W-1:0] * ADDR_W'(SCREEN_W) + pix_x[ADDR_W-1:0];

  assign {w_head_addr, w_head_data, w_head_last} = r_mem[r_rptr];

  assign w_pend_fire = r_done_pending & w_empty & (r_state == S_IDLE);

  always_ff @(posedge pll_clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_addr, pix_color, pix_last};
    end
  end

  always_ff @(posedge pll_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_req          <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_last         <= 1'b0;
      r_done         <= 1'b0;
      r_done_pending <= 1'b0;
      r_clip_count   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (w_clip && (r_clip_count != 16'hFFFF)) begin
        r_clip_count <= r_clip_count + 16'd1;
      end

      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head_addr;
            r_data  <= w_head_data;
            r_last  <= w_head_last;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            if (r_last) r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A pending pulse only fires in IDLE, so it never doubles a write-completion pulse.
      if (w_pend_fire) r_done <= 1'b1;
      r_done_pending <= (r_done_pending & ~w_pend_fire) | (w_clip & pix_last);
    end
  end

  assign mem_req    = r_req;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign clip_count = r_clip_count;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Downstream of the Bresenham line rasteriser; consumes its stream of (x, y) pixel coordinates plus a colour.
- Clips each pixel against the screen and converts in-bounds pixels to linear framebuffer addresses (y*SCREEN_W + x).
- Buffers them in a small FIFO and issues one req/ack write per pixel to the framebuffer memory port.
- Pulses done when the final pixel of a line has been retired.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
COORD_W, 32, coordinate width (matches rasteriser x/y registers)
ADDR_W, 19, framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
COLOR_W, 16, pixel colour width
FIFO_DEPTH, 4, pixel FIFO entries (power of two, >=2)

Ports:
pll_clock  in  1  system clock, all logic on rising edge
sys_reset  in  1  asynchronous, active-low reset (0 = reset)
pix_valid  in  1  rasteriser presents a pixel
pix_ready  out  1  block can accept a pixel this cycle
pix_x  in  COORD_W  pixel x, unsigned
pix_y  in  COORD_W  pixel y, unsigned
pix_color  in  COLOR_W  pixel colour
pix_last  in  1  pixel is the final point of the current line
mem_req  out  1  write request to framebuffer
mem_ack  in  1  framebuffer accepted the write
mem_addr  out  ADDR_W  write address
mem_data  out  COLOR_W  write data
clip_count  out  16  number of discarded out-of-bounds pixels, saturating
done  out  1  one-cycle pulse when the last pixel of a line is retired

Behaviour:
- Reset (sys_reset=0, asynchronous):
  - FIFO empties.
  - FSM goes to IDLE.
  - mem_req, mem_addr, mem_data, clip_count, done and the done_pending flag go to 0.
  - pix_ready is forced to 0 while in reset.
- Reset mid-transaction discards all buffered pixels and any outstanding write; mem_req drops immediately.
- Input handshake:
  - A pixel is accepted on a rising edge with pix_valid=1 and pix_ready=1.
  - pix_ready = !fifo_full, with no combinational path from mem_ack. When full, ready stays 0 even in a cycle where a pop occurs.
- Clipping:
  - A pixel is out of bounds if pix_x >= SCREEN_W or pix_y >= SCREEN_H, unsigned compare. Negative values wrapped from the rasteriser therefore clip.
  - Clipped pixels are not pushed.
  - clip_count increments by 1 per clipped pixel and saturates at 16'hFFFF.
- Address:
  - addr = pix_y*SCREEN_W + pix_x, computed combinationally at accept time and truncated to ADDR_W.
  - The FIFO stores {addr, color, last}.
- Output FSM, two states:
  - IDLE: if the FIFO is non-empty, pop the head into mem_addr/mem_data/last_r, set mem_req=1 and go to REQ.
  - REQ: hold mem_req, mem_addr and mem_data stable until mem_ack=1 is sampled. On ack: mem_req<=0, go to IDLE, and if last_r set, done<=1 for one cycle.
  - Minimum 2 cycles per pixel; an accept-to-mem_req latency of 1 cycle when the FIFO is empty and the FSM is IDLE.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- Last-pixel handling:
  - A clipped pixel with pix_last=1 sets done_pending.
  - done pulses for one cycle when done_pending=1, the FIFO is empty and the FSM is IDLE; done_pending then clears.
  - If a written-last and a pending-last would both pulse in the same cycle, a single pulse is issued.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. An extra count register distinguishes full from empty.

Test Plan:
1. Reset release, single pixel (x=100, y=200, color=16'hF800, last=1), mem_ack one cycle after mem_req -> mem_req rises 1 cycle after accept, mem_addr=128100, mem_data=16'hF800; done pulses 1 cycle after ack; clip_count=0.
2. Clipping: pixels (640,0), (0,480), (32'hFFFFFFFF,5) -> no mem_req, clip_count=3; a 4th clipped pixel with last=1 -> done pulses once the FIFO is idle and empty.
3. Backpressure: mem_ack held 0, stream 6 in-bounds pixels -> pix_ready drops after 4 accepts plus 1 held in the output register, and mem_addr stays stable; releasing ack drains all 5 in order at one pixel per 2 cycles.
4. Full line (100,200)->(200,300) from the rasteriser model, 101 pixels, ack always 1 -> 101 writes with addresses y*640+x in order; exactly one done pulse after the final write.
5. Async reset asserted mid-REQ with 3 pixels buffered -> mem_req=0 and pix_ready=0 immediately, no further writes after release, clip_count=0.
6. Saturation: 65540 clipped pixels -> clip_count stays at 16'hFFFF.
